// File: rtl/change_dispenser.sv
// change_dispenser: greedy Rs5/Rs2/Rs1 change dispenser over a valid/ack hopper handshake with per-coin stock.
// Optional ack watchdog enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 6,
  parameter int STOCK_INIT = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             coin_req,
  output logic [2:0]       coin_code,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [2:0]       refill_code,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic             busy,
  output logic             done,
  output logic             short_err,
  output logic             timeout_err,
  output logic [AMT_W-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] stk5, stk2, stk1, stk5_n, stk2_n, stk1_n;
  logic [AMT_W-1:0] rem_n;
  logic [2:0] sel, code_n;
  logic req_n, done_n, short_n, to_n;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  // coin codes equal their rupee value, so the code doubles as the amount to subtract
  assign sel = (remaining >= AMT_W'(5) && stk5 != '0) ? 3'b101 :
               (remaining >= AMT_W'(2) && stk2 != '0) ? 3'b010 :
               (remaining >= AMT_W'(1) && stk1 != '0) ? 3'b001 : 3'b000;
`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wd, wd_n;
`endif
  always_comb begin
    state_n = state;
    rem_n = remaining;
    stk5_n = stk5;
    stk2_n = stk2;
    stk1_n = stk1;
    req_n = coin_req;
    code_n = coin_code;
    done_n = 1'b0;
    short_n = 1'b0;
    to_n = 1'b0;
`ifdef CHANGE_ACK_TIMEOUT_EN
    wd_n = '0;
`endif
    case (state)
      IDLE: begin
        stk5_n = (refill && refill_code == 3'b101) ? sat_add(stk5, refill_cnt) : stk5;
        stk2_n = (refill && refill_code == 3'b010) ? sat_add(stk2, refill_cnt) : stk2;
        stk1_n = (refill && refill_code == 3'b001) ? sat_add(stk1, refill_cnt) : stk1;
        rem_n = start ? amount : remaining;
        state_n = start ? SELECT : IDLE;
      end
      SELECT: begin
        req_n = sel != 3'b000;
        code_n = sel;
        done_n = sel == 3'b000 && remaining == '0;
        short_n = sel == 3'b000 && remaining != '0;
        state_n = sel != 3'b000 ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        if (coin_ack) begin
          req_n = 1'b0;
          code_n = 3'b000;
          rem_n = remaining - AMT_W'(coin_code);
          stk5_n = coin_code == 3'b101 ? stk5 - CNT_W'(1) : stk5;
          stk2_n = coin_code == 3'b010 ? stk2 - CNT_W'(1) : stk2;
          stk1_n = coin_code == 3'b001 ? stk1 - CNT_W'(1) : stk1;
          state_n = SELECT;
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else begin
          wd_n = wd + TO_W'(1);
          to_n = wd_n == TO_W'(TIMEOUT);
          req_n = !to_n;
          code_n = to_n ? 3'b000 : coin_code;
          state_n = to_n ? IDLE : WAIT_ACK;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      stk5 <= CNT_W'(STOCK_INIT);
      stk2 <= CNT_W'(STOCK_INIT);
      stk1 <= CNT_W'(STOCK_INIT);
      coin_req <= 1'b0;
      coin_code <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      short_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      remaining <= rem_n;
      stk5 <= stk5_n;
      stk2 <= stk2_n;
      stk1 <= stk1_n;
      coin_req <= req_n;
      coin_code <= code_n;
      busy <= state_n != IDLE;
      done <= done_n;
      short_err <= short_n;
      timeout_err <= to_n;
    end
  end
`ifdef CHANGE_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd <= '0;
    else wd <= wd_n;
  end
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized check of change_dispenser against a greedy coin/stock reference model.
module tb_change_dispenser;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, coin_ack = 1'b0, refill = 1'b0;
  logic [7:0] amount = '0;
  logic [2:0] refill_code = '0;
  logic [5:0] refill_cnt = '0;
  logic coin_req, busy, done, short_err, timeout_err;
  logic [2:0] coin_code;
  logic [7:0] remaining;
  int checks = 0, errors = 0;
  int s5, s2, s1;

  change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .coin_req(coin_req), .coin_code(coin_code), .coin_ack(coin_ack),
    .refill(refill), .refill_code(refill_code), .refill_cnt(refill_cnt),
    .busy(busy), .done(done), .short_err(short_err), .timeout_err(timeout_err),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input int rem);
    if (rem >= 5 && s5 > 0) return 5;
    if (rem >= 2 && s2 > 0) return 2;
    if (rem >= 1 && s1 > 0) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return v > 63 ? 63 : v;
  endfunction

  task automatic model_refill(input int code, input int cnt);
    if (code == 5) s5 = sat(s5 + cnt);
    if (code == 2) s2 = sat(s2 + cnt);
    if (code == 1) s1 = sat(s1 + cnt);
  endtask

  task automatic check_stock(input string tag);
    check({tag, "_stk5"}, int'(dut.stk5), s5);
    check({tag, "_stk2"}, int'(dut.stk2), s2);
    check({tag, "_stk1"}, int'(dut.stk1), s1);
  endtask

  task automatic idle_refill(input int code, input int cnt);
    int rem0;
    rem0 = remaining;
    refill = 1'b1; refill_code = 3'(code); refill_cnt = 6'(cnt); coin_ack = 1'b1;
    model_refill(code, cnt);
    tick;
    refill = 1'b0; coin_ack = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_req", coin_req, 0);
    check("idle_rem", remaining, rem0);
    check_stock("refill");
  endtask

  task automatic run(input int amt, input int maxd, input bit allow_refill);
    int rem, c, d, code, cnt;
    bit rf;
    rf = allow_refill && $urandom_range(0, 3) == 0;
    code = $urandom_range(0, 7);
    cnt = $urandom_range(0, 63);
    start = 1'b1; amount = 8'(amt);
    refill = rf; refill_code = 3'(code); refill_cnt = 6'(cnt);
    if (rf) model_refill(code, cnt);
    tick;
    start = 1'b0; refill = 1'b0;
    check("busy_sel", busy, 1);
    check("rem_load", remaining, amt);
    rem = amt;
    for (int k = 0; k < 300; k++) begin
      c = pick(rem);
      tick;
      if (c == 0) break;
      check("req", coin_req, 1);
      check("code", coin_code, c);
      d = $urandom_range(0, maxd);
      for (int i = 0; i < d; i++) begin
        start = 1'($urandom_range(0, 1)); amount = 8'($urandom);
        refill = 1'($urandom_range(0, 1)); refill_code = 3'b101; refill_cnt = 6'($urandom_range(1, 63));
        tick;
        start = 1'b0; refill = 1'b0;
        check("req_hold", coin_req, 1);
        check("code_hold", coin_code, c);
      end
      coin_ack = 1'b1;
      tick;
      coin_ack = 1'b0;
      rem -= c;
      if (c == 5) s5--;
      if (c == 2) s2--;
      if (c == 1) s1--;
      check("req_drop", coin_req, 0);
      check("code_clr", coin_code, 0);
      check("rem_step", remaining, rem);
    end
    check("done", done, rem == 0);
    check("short_err", short_err, rem != 0);
    check("rem_final", remaining, rem);
    check("busy_end", busy, 0);
    check("req_end", coin_req, 0);
    check("timeout_err", timeout_err, 0);
    tick;
    check("done_pulse", done, 0);
    check("short_pulse", short_err, 0);
    check("rem_hold", remaining, rem);
    check_stock("txn");
  endtask

  initial begin
    s5 = 20; s2 = 20; s1 = 20;
    tick;
    tick;
    check("rst_req", coin_req, 0);
    check("rst_code", coin_code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_err, 0);
    check("rst_to", timeout_err, 0);
    check("rst_rem", remaining, 0);
    check_stock("rst");
    rst = 1'b0;
    tick;
    run(8, 0, 1'b0);
    run(0, 0, 1'b0);
    idle_refill(5, 10);
    idle_refill(5, 50);
    idle_refill(3, 7);
    idle_refill(2, 1);
    run(11, 3, 1'b0);
    start = 1'b1; amount = 8'd50;
    tick;
    start = 1'b0;
    tick;
    check("pre_rst_req", coin_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_req", coin_req, 0);
    check("async_code", coin_code, 0);
    check("async_busy", busy, 0);
    check("async_rem", remaining, 0);
    s5 = 20; s2 = 20; s1 = 20;
    check_stock("async");
    @(negedge clk);
    rst = 1'b0;
    tick;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) idle_refill($urandom_range(0, 7), $urandom_range(0, 63));
      run($urandom_range(0, 3) == 0 ? $urandom_range(0, 12) : $urandom_range(0, 255), 3, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
